// File: rtl/vend_balance.sv
// vend_balance -- credit accumulator and purchase controller for a vending machine.
//
// Tracks the customer's inserted credit, accepts or refuses coins against a
// balance ceiling, approves or rejects purchases against the latched item price,
// dwells in VEND for HOLD_CYCLES cycles after each sale and refunds credit on
// cancel. All outputs are registered.
//
// Optional build macro:
//   VEND_AUTO_CHANGE_EN  when defined, any credit left after a sale is refunded
//                        automatically; when undefined, that credit is kept for
//                        further purchases.
//
// Parameters:
//   HOLD_CYCLES   sys_clk cycles spent in VEND after a purchase
//   MAX_BAL       balance ceiling (stays within the 0..999 display converter)
//
// Ports:
//   sys_clk       system clock, rising edge
//   sys_rst_n     asynchronous active-low reset
//   coin_vld      coin-accepted strobe, coin_type sampled with it
//   coin_type     00=1, 01=5, 10=10, 11=50 units
//   sel_vld       item-select strobe, sel_price sampled with it
//   sel_price     item price in units
//   buy_req       purchase request strobe
//   cancel        refund request strobe
//   balance       current credit, 0..MAX_BAL
//   change_out    refund amount, valid with change_vld, held between refunds
//   change_vld    one-cycle refund strobe
//   vend_ok       one-cycle purchase-accepted strobe
//   insufficient  one-cycle purchase-rejected strobe
//   coin_reject   one-cycle coin-refused strobe
//   busy          high while in VEND or CHANGE
module vend_balance #(
    parameter logic [23:0] HOLD_CYCLES = 24'd50,
    parameter logic [9:0]  MAX_BAL     = 10'd999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       coin_vld,
    input  logic [1:0] coin_type,
    input  logic       sel_vld,
    input  logic [9:0] sel_price,
    input  logic       buy_req,
    input  logic       cancel,
    output logic [9:0] balance,
    output logic [9:0] change_out,
    output logic       change_vld,
    output logic       vend_ok,
    output logic       insufficient,
    output logic       coin_reject,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    state_t      state;
    logic [9:0]  price;
    logic [23:0] hold_cnt;
    logic [10:0] coin_sum;
    logic        coin_fits;
    logic        hold_done;

    function automatic logic [9:0] coin_value(input logic [1:0] t);
        case (t)
            2'b00: return 10'd1;
            2'b01: return 10'd5;
            2'b10: return 10'd10;
            2'b11: return 10'd50;
        endcase
    endfunction

    // Sum is one bit wider than the balance so an over-ceiling coin can never
    // wrap around into an apparently valid value.
    assign coin_sum  = {1'b0, balance} + {1'b0, coin_value(coin_type)};
    assign coin_fits = (coin_sum <= {1'b0, MAX_BAL});
    assign hold_done = (({1'b0, hold_cnt} + 25'd1) >= {1'b0, HOLD_CYCLES});

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            balance      <= 10'd0;
            change_out   <= 10'd0;
            price        <= 10'd0;
            hold_cnt     <= 24'd0;
            change_vld   <= 1'b0;
            vend_ok      <= 1'b0;
            insufficient <= 1'b0;
            coin_reject  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            change_vld   <= 1'b0;
            vend_ok      <= 1'b0;
            insufficient <= 1'b0;
            coin_reject  <= 1'b0;

            if (sel_vld) begin
                price <= sel_price;
            end

            case (state)
                IDLE, ACCUM: begin
                    // cancel beats buy_req beats coin_vld; a coin arriving with
                    // either of the others is handed back.
                    if (cancel) begin
                        coin_reject <= coin_vld;
                        state       <= CHANGE;
                        busy        <= 1'b1;
                    end else if (buy_req && (state == ACCUM)) begin
                        coin_reject <= coin_vld;
                        if ((price != 10'd0) && (balance >= price)) begin
                            balance  <= balance - price;
                            vend_ok  <= 1'b1;
                            hold_cnt <= 24'd0;
                            state    <= VEND;
                            busy     <= 1'b1;
                        end else begin
                            insufficient <= 1'b1;
                        end
                    end else if (coin_vld) begin
                        if (coin_fits) begin
                            balance <= coin_sum[9:0];
                            state   <= ACCUM;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end

                VEND: begin
                    coin_reject <= coin_vld;
                    if (hold_done) begin
                        hold_cnt <= 24'd0;
`ifdef VEND_AUTO_CHANGE_EN
                        if (balance != 10'd0) begin
                            state <= CHANGE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
`else
                        state <= (balance != 10'd0) ? ACCUM : IDLE;
                        busy  <= 1'b0;
`endif
                    end else begin
                        hold_cnt <= hold_cnt + 24'd1;
                    end
                end

                CHANGE: begin
                    // Refund strobe fires even for a zero balance so the
                    // cancel always gets an acknowledgement.
                    coin_reject <= coin_vld;
                    change_out  <= balance;
                    change_vld  <= 1'b1;
                    balance     <= 10'd0;
                    state       <= IDLE;
                    busy        <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/vend_balance.md
VEND_BALANCE -- requirements
Module: vend_balance

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 24'd50, giving the number of sys_clk cycles the block dwells in VEND.
REQ-002 SHALL have parameter MAX_BAL, default 10'd999, giving the balance ceiling so the balance always fits the 0~999 BCD converter stage downstream.
REQ-003 SHALL have port sys_clk, input, 1 bit: system clock; all logic on rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port coin_vld, input, 1 bit: single-cycle coin-accepted strobe.
REQ-006 SHALL have port coin_type, input, 2 bits: coin value, 00=1, 01=5, 10=10, 11=50 units; sampled with coin_vld.
REQ-007 SHALL have port sel_vld, input, 1 bit: single-cycle item-select strobe.
REQ-008 SHALL have port sel_price, input, 10 bits: item price in units; sampled with sel_vld.
REQ-009 SHALL have port buy_req, input, 1 bit: single-cycle purchase request.
REQ-010 SHALL have port cancel, input, 1 bit: single-cycle refund request.
REQ-011 SHALL have port balance, output, 10 bits: registered current credit, 0..MAX_BAL; feeds the binary-to-BCD display stage.
REQ-012 SHALL have port change_out, output, 10 bits: refund amount, valid with change_vld.
REQ-013 SHALL have port change_vld, output, 1 bit: one-cycle refund strobe.
REQ-014 SHALL have port vend_ok, output, 1 bit: one-cycle purchase-accepted strobe.
REQ-015 SHALL have port insufficient, output, 1 bit: one-cycle purchase-rejected strobe.
REQ-016 SHALL have port coin_reject, output, 1 bit: one-cycle coin-refused strobe.
REQ-017 SHALL have port busy, output, 1 bit: high while in VEND or CHANGE.

Function
REQ-018 SHALL implement FSM states IDLE, ACCUM, VEND and CHANGE; all outputs are registered, and each response appears on the cycle after the triggering strobe.
REQ-019 SHALL, in IDLE or ACCUM on coin_vld, set balance to balance+value and enter ACCUM, provided the sum is <= MAX_BAL.
REQ-020 SHALL, when balance+value would exceed MAX_BAL, leave balance unchanged and pulse coin_reject for one cycle; the sum is computed 11 bits wide, so no wrap.
REQ-021 SHALL, on sel_vld in any state, latch sel_price into the internal price register, which resets to 0.
REQ-022 SHALL, in ACCUM on buy_req with price!=0 and balance>=price, set balance to balance-price, pulse vend_ok and enter VEND.
REQ-023 SHALL, in ACCUM on buy_req with price==0 or balance<price, pulse insufficient and leave state and balance unchanged.
REQ-024 SHALL ignore buy_req in IDLE.
REQ-025 SHALL, in IDLE or ACCUM on cancel, enter CHANGE.
REQ-026 SHALL, in VEND, count HOLD_CYCLES cycles and then exit per REQ-031; vend_ok is not repeated during the dwell.
REQ-027 SHALL, in CHANGE, for one cycle set change_out to balance and pulse change_vld (also when balance is 0), set balance to 0 and enter IDLE.
REQ-028 SHALL resolve simultaneous strobes with priority cancel > buy_req > coin_vld; the losing coin is refused via coin_reject.
REQ-029 SHALL, on coin_vld in VEND or CHANGE, pulse coin_reject and leave balance unchanged.
REQ-030 SHALL hold change_out at its last value between refunds.

Configuration
REQ-031 SHALL use macro VEND_AUTO_CHANGE_EN to select VEND exit: when defined, VEND exits to CHANGE, refunding the remainder, or to IDLE if the remainder is 0; when undefined, VEND exits to ACCUM if the remainder is >0, else to IDLE, keeping credit for further purchases.

Reset
REQ-032 SHALL, while sys_rst_n is low, asynchronously force state=IDLE, balance=0, change_out=0, price=0, hold counter=0 and all strobes plus busy=0.
REQ-033 SHALL, on reset asserted mid-VEND or mid-CHANGE, discard the credit with no change_vld; after release the FSM starts in IDLE.

Verification
REQ-034 SHALL be verified by: coins 10,10,5 then sel_price=20 and buy_req -> vend_ok; balance 25 then 5; busy high for HOLD_CYCLES.
REQ-035 SHALL be verified by: with VEND_AUTO_CHANGE_EN defined, the REQ-034 sequence -> change_vld with change_out=5 and balance=0; undefined -> ACCUM with balance=5.
REQ-036 SHALL be verified by: balance 980, coin 50 -> coin_reject with balance 980; then coin 10 -> 990, coin 5 -> 995, coin 1 four times -> 999, and the next coin 1 -> coin_reject.
REQ-037 SHALL be verified by: balance 15, sel_price=20, buy_req -> insufficient with balance 15; buy_req with price 0 -> insufficient.
REQ-038 SHALL be verified by: cancel, buy_req and coin_vld in the same cycle at balance 30 -> change_out=30, coin_reject, no vend_ok, balance 0.
REQ-039 SHALL be verified by: reset pulse mid-VEND -> all outputs 0 asynchronously, state IDLE, no change_vld.
